// File: rtl/bp_me_cache_dma_initiator.sv
// Block-level DMA initiator: accepts one cache-line read or write request,
// issues a single DMA packet, then streams burst_len_p data beats in or out
// and returns a completion carrying the assembled line (reads) or zero (writes).
module bp_me_cache_dma_initiator #(
  parameter int addr_width_p    = 28,
  parameter int data_width_p    = 64,
  parameter int burst_len_p     = 8,
  parameter int mask_width_p    = 8,
  localparam int line_width_lp   = data_width_p * burst_len_p,
  localparam int block_offset_lp = $clog2(line_width_lp / 8)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     req_v_i,
  output logic                     req_ready_and_o,
  input  logic                     req_we_i,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic [mask_width_p-1:0]  req_mask_i,
  input  logic [line_width_lp-1:0] req_data_i,

  output logic                     resp_v_o,
  input  logic                     resp_ready_and_i,
  output logic                     resp_we_o,
  output logic [line_width_lp-1:0] resp_data_o,

  output logic                     dma_pkt_v_o,
  input  logic                     dma_pkt_yumi_i,
  output logic                     dma_pkt_write_not_read_o,
  output logic [addr_width_p-1:0]  dma_pkt_addr_o,
  output logic [mask_width_p-1:0]  dma_pkt_mask_o,

  output logic [data_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_yumi_i,

  input  logic [data_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_ready_and_o
);

  localparam int cnt_width_lp = $clog2(burst_len_p);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(burst_len_p - 1);
  // Byte-within-block bits, cleared on the outgoing packet address
  localparam logic [addr_width_p-1:0] offset_bits_lp =
    {{(addr_width_p - block_offset_lp){1'b0}}, {block_offset_lp{1'b1}}};

  typedef enum logic [2:0] {
    e_idle  = 3'd0,
    e_pkt   = 3'd1,
    e_wdata = 3'd2,
    e_rdata = 3'd3,
    e_resp  = 3'd4
  } state_e;

  state_e                    state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
  // Holds ready low until the first clock edge after reset release
  logic                      out_of_reset_r;

  logic                      we_r;
  logic [addr_width_p-1:0]   addr_r;
  logic [mask_width_p-1:0]   mask_r;
  logic [line_width_lp-1:0]  line_r;

  logic                      req_fire;

  assign req_fire = req_v_i & req_ready_and_o;

  // Control state: FSM state, beat counter and reset-release flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r        <= e_idle;
      cnt_r          <= '0;
      out_of_reset_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      cnt_r          <= cnt_n;
      out_of_reset_r <= 1'b1;
    end
  end

  // Next state and beat counter; counter wraps to 0 after the last beat
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      e_idle: begin
        if (req_fire) state_n = e_pkt;
      end
      e_pkt: begin
        if (dma_pkt_yumi_i) begin
          state_n = we_r ? e_wdata : e_rdata;
          cnt_n   = '0;
        end
      end
      e_wdata: begin
        if (dma_data_yumi_i) begin
          cnt_n = cnt_r + 1'b1;
          if (cnt_r == last_cnt_lp) state_n = e_resp;
        end
      end
      e_rdata: begin
        if (dma_data_v_i) begin
          cnt_n = cnt_r + 1'b1;
          if (cnt_r == last_cnt_lp) state_n = e_resp;
        end
      end
      e_resp: begin
        if (resp_ready_and_i) state_n = e_idle;
      end
      default: begin
        state_n = e_idle;
        cnt_n   = '0;
      end
    endcase
  end

  // Handshake outputs decoded from the current state only
  always_comb begin
    req_ready_and_o      = 1'b0;
    dma_pkt_v_o          = 1'b0;
    dma_data_v_o         = 1'b0;
    dma_data_ready_and_o = 1'b0;
    resp_v_o             = 1'b0;
    unique case (state_r)
      e_idle:  req_ready_and_o      = out_of_reset_r;
      e_pkt:   dma_pkt_v_o          = 1'b1;
      e_wdata: dma_data_v_o         = 1'b1;
      e_rdata: dma_data_ready_and_o = 1'b1;
      e_resp:  resp_v_o             = 1'b1;
      default: ;
    endcase
  end

  // Request capture and read-beat assembly into the line buffer
  always_ff @(posedge clk_i) begin
    if (state_r == e_idle && req_fire) begin
      we_r   <= req_we_i;
      addr_r <= req_addr_i;
      mask_r <= req_mask_i;
      line_r <= req_data_i;
    end else if (state_r == e_rdata && dma_data_v_i) begin
      line_r[int'(cnt_r) * data_width_p +: data_width_p] <= dma_data_i;
    end
  end

  assign dma_pkt_write_not_read_o = we_r;
  assign dma_pkt_addr_o           = addr_r & ~offset_bits_lp;
  assign dma_pkt_mask_o           = we_r ? mask_r : '1;
  assign dma_data_o               = line_r[int'(cnt_r) * data_width_p +: data_width_p];
  assign resp_we_o                = (state_r == e_resp) & we_r;
  assign resp_data_o              = (state_r == e_resp && !we_r) ? line_r : '0;

endmodule

// File: doc/bp_me_cache_dma_initiator.md
BP_ME_CACHE_DMA_INITIATOR -- requirements
Module: bp_me_cache_dma_initiator

Interface
REQ-001 SHALL have parameter addr_width_p, default 28, DMA byte-address width.
REQ-002 SHALL have parameter data_width_p, default 64, DMA data beat width (bits).
REQ-003 SHALL have parameter burst_len_p, default 8, beats per block; power of two, >=2.
REQ-004 SHALL have parameter mask_width_p, default 8, per-word write mask width (bsg_cache_dma mask).
REQ-005 SHALL use line_width = data_width_p*burst_len_p and block_offset = log2(line_width/8).
REQ-006 SHALL have ports (name dir width meaning), as listed:
 clk_i  in  1  single clock, all logic rising-edge.
 reset_n_i  in  1  reset, asynchronous, active-low.
 req_v_i / req_ready_and_o  in / out  1 / 1  request handshake (ready-and).
 req_we_i  in  1  1=block write, 0=block read.
 req_addr_i  in  addr_width_p  block byte address.
 req_mask_i  in  mask_width_p  write word mask; ignored for reads.
 req_data_i  in  line_width  write block data.
 resp_v_o / resp_ready_and_i  out / in  1 / 1  completion handshake (ready-and).
 resp_we_o  out  1  echo of request type.
 resp_data_o  out  line_width  read block data; 0 for writes.
 dma_pkt_v_o / dma_pkt_yumi_i  out / in  1 / 1  DMA packet (valid-yumi).
 dma_pkt_write_not_read_o  out  1  packet type.
 dma_pkt_addr_o  out  addr_width_p  block-aligned address.
 dma_pkt_mask_o  out  mask_width_p  write mask; all-ones for reads.
 dma_data_o / dma_data_v_o / dma_data_yumi_i  out / out / in  data_width_p / 1 / 1  write beats (valid-yumi).
 dma_data_i / dma_data_v_i / dma_data_ready_and_o  in / in / out  data_width_p / 1 / 1  read beats (ready-and).

Function
REQ-007 SHALL implement FSM states IDLE, PKT, WDATA, RDATA, RESP; one request in flight.
REQ-008 IDLE: req_ready_and_o=1; on req_v_i&req_ready_and_o capture we, addr (low block_offset bits forced 0), mask, data; go PKT next cycle.
REQ-009 PKT: dma_pkt_v_o=1 with fields stable until dma_pkt_yumi_i; on yumi go WDATA if write else RDATA; beat counter cleared.
REQ-010 dma_pkt_v_o SHALL NOT depend combinationally on dma_pkt_yumi_i; yumi while v=0 is illegal and SHALL be ignored.
REQ-011 WDATA: dma_data_v_o=1, dma_data_o = captured line bits [(k+1)*data_width_p-1 : k*data_width_p] for beat k; counter increments on dma_data_yumi_i.
REQ-012 WDATA: yumi on beat burst_len_p-1 SHALL go RESP; exactly burst_len_p beats per write, including when mask is zero.
REQ-013 RDATA: dma_data_ready_and_o=1; each dma_data_i beat with v=1 written to line slot k, counter increments; last beat goes RESP.
REQ-014 dma_data_ready_and_o SHALL be 0 outside RDATA; read beats arriving then SHALL be dropped without state change.
REQ-015 RESP: resp_v_o=1, resp_we_o and resp_data_o stable until resp_ready_and_i; on handshake go IDLE.
REQ-016 req_ready_and_o SHALL be 0 in all states except IDLE; no request accepted in the RESP handshake cycle (min 1 idle cycle between responses and next accept).
REQ-017 Beat counter SHALL be log2(burst_len_p) bits and wrap to 0 after last beat.
REQ-018 Minimum latency: accept at cycle 0 -> packet valid cycle 1 -> with immediate yumi/valid each cycle, resp_v_o at cycle 2+burst_len_p.
REQ-019 Backpressure on any channel SHALL stall only that state; no output changes while stalled.

Reset
REQ-020 reset_n_i low SHALL asynchronously force IDLE, counter 0, resp_data_o 0; outputs: req_ready_and_o=0 during reset, 1 after first edge out of reset; all v/ready outputs 0.
REQ-021 Reset mid-burst SHALL abandon transaction without further beats; no resp issued.

Verification
REQ-022 Read addr 0x0000_0047, memory beats 0x11..0x88 with no stalls -> pkt addr 0x0000_0040, mask 0xFF, write_not_read 0; resp_data_o[63:0]=0x11, [511:448]=0x88, resp_v_o at cycle 10.
REQ-023 Write addr 0x0000_1000, mask 0x0F, data beat k = k -> pkt write_not_read 1 mask 0x0F; eight beats 0..7 in order; resp_we_o=1, resp_data_o=0.
REQ-024 dma_pkt_yumi_i held 0 for 5 cycles -> pkt fields unchanged, no data beats, req_ready_and_o=0 throughout.
REQ-025 Read with dma_data_v_i toggling every other cycle and resp_ready_and_i low 3 cycles -> correct 8-beat assembly; resp held stable 4 cycles.
REQ-026 reset_n_i asserted after write beat 3 -> no further beats, all valids 0 immediately, IDLE after release; following read completes normally.
REQ-027 Back-to-back requests with req_v_i held 1 -> second accepted only in IDLE cycle after first resp handshake.
